// File: rtl/apb_rr_master_bridge_pkg.sv
// Shared types for the round-robin APB master bridge: bus FSM states and response status.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic slverr;
        logic timeout;
    } rsp_status_t;

endpackage

// File: rtl/apb_rr_master_bridge_if.sv
// APB bus bundle between the bridge (master) and the peripheral fabric (slave).
// Optional APB4 sideband (PSTRB, PPROT) is present only when APB4_EN is defined.
interface apb_rr_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) ();
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [NUM_CH-1:0]     PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
`ifdef APB4_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [2:0]              PPROT;
`endif

    modport master (
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
`ifdef APB4_EN
        output PSTRB, PPROT,
`endif
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
`ifdef APB4_EN
        input  PSTRB, PPROT,
`endif
        output PREADY, PSLVERR, PRDATA
    );
endinterface

// File: rtl/apb_rr_master_bridge_arb.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 advance,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant
);
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (advance && !found && req[(int'(last_grant) + k) % N]) begin
                grant[(int'(last_grant) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb_rr_master_bridge.sv
// Multi-channel APB master with round-robin arbitration and a wait-state watchdog.
// Define APB4_EN to add PSTRB/PPROT and the matching per-channel request inputs.
module apb_rr_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    apb_rr_master_bridge_if.master       apb,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
`ifdef APB4_EN
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] req_strb,
    input  logic [NUM_CH*3-1:0]            req_prot,
`endif
    output logic [NUM_CH-1:0]            req_ready,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_slverr,
    output logic                         rsp_timeout
);
    localparam int LGW = $clog2(NUM_CH);
    localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCW-1:0] WC_LAST  = WCW'(TIMEOUT_CYCLES - 1);
    localparam logic [LGW-1:0] LG_RESET = LGW'(NUM_CH - 1);

    apb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [NUM_CH-1:0]     psel_q, psel_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [NUM_CH-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    rsp_status_t           status_q, status_d;
    logic [LGW-1:0]        last_grant_q, last_grant_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
`ifdef APB4_EN
    logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
`endif

    logic [NUM_CH-1:0] grant;
    logic [LGW-1:0]    grant_idx;
    logic              grant_pt;
    logic              accept;

    assign grant_pt = (state_q == IDLE) || ((state_q == ACCESS) && apb.PREADY);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req        (req_valid),
        .advance    (grant_pt),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = LGW'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        psel_d       = psel_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        status_d     = status_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
`ifdef APB4_EN
        pstrb_d      = pstrb_q;
        pprot_d      = pprot_q;
`endif
        case (state_q)
            IDLE: ;
            SETUP: begin
                state_d    = ACCESS;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    rsp_valid_d     = psel_q;
                    if (!pwrite_q) rsp_rdata_d = apb.PRDATA;
                    status_d.slverr  = apb.PSLVERR;
                    status_d.timeout = 1'b0;
                    state_d         = IDLE;
                    psel_d          = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (wait_cnt_q == WC_LAST) begin
                        // Watchdog abort: report to the owner and release the bus without a grant.
                        rsp_valid_d      = psel_q;
                        status_d.slverr  = 1'b0;
                        status_d.timeout = 1'b1;
                        state_d          = IDLE;
                        psel_d           = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                paddr_d      = '0;
                psel_d       = '0;
                pwrite_d     = 1'b0;
                pwdata_d     = '0;
                rsp_rdata_d  = '0;
                status_d     = '0;
                last_grant_d = LG_RESET;
                wait_cnt_d   = '0;
`ifdef APB4_EN
                pstrb_d      = '0;
                pprot_d      = '0;
`endif
            end
        endcase

        // A grant overrides the IDLE fall-through so completion and the next setup overlap.
        if (accept) begin
            state_d      = SETUP;
            psel_d       = grant;
            last_grant_d = grant_idx;
            paddr_d      = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            pwrite_d     = req_write[grant_idx];
            if (req_write[grant_idx]) pwdata_d = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef APB4_EN
            pstrb_d      = req_write[grant_idx]
                         ? req_strb[int'(grant_idx)*(DATA_WIDTH/8) +: DATA_WIDTH/8] : '0;
            pprot_d      = req_prot[int'(grant_idx)*3 +: 3];
`endif
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            psel_q       <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            status_q     <= '0;
            last_grant_q <= LG_RESET;
            wait_cnt_q   <= '0;
`ifdef APB4_EN
            pstrb_q      <= '0;
            pprot_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            psel_q       <= psel_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            status_q     <= status_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef APB4_EN
            pstrb_q      <= pstrb_d;
            pprot_q      <= pprot_d;
`endif
        end
    end

    assign apb.PADDR   = paddr_q;
    assign apb.PSELx   = psel_q;
    assign apb.PENABLE = (state_q == ACCESS);
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;
`ifdef APB4_EN
    assign apb.PSTRB   = pstrb_q;
    assign apb.PPROT   = pprot_q;
`endif
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = status_q.slverr;
    assign rsp_timeout = status_q.timeout;
endmodule

// File: doc/apb_rr_master_bridge.md
# apb_rr_master_bridge

Multi-channel APB master bridge. It arbitrates read/write requests from NUM_CH independent requesters with a true round-robin policy and issues them as APB transfers on one shared bus. PSELx carries one select per channel. Back-to-back transfers run without an idle cycle, and a wait-state watchdog aborts hung transfers. It sits between internal memory-mapped clients and the peripheral APB fabric, and generalises the single-select bridge in channel count, handshake and error reporting.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width
- ADDR_WIDTH, 32, PADDR width
- NUM_CH, 4, requester channels and PSELx width (≥2)
- TIMEOUT_CYCLES, 16, max ACCESS wait states before abort; 0 disables the watchdog
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PADDR  out  ADDR_WIDTH  APB address
- PSELx  out  NUM_CH  one-hot select, bit i = channel i
- PENABLE, PWRITE  out  1  APB phase / direction
- PWDATA  out  DATA_WIDTH  write data
- PREADY, PSLVERR  in  1  slave ready / error
- PRDATA  in  DATA_WIDTH  read data
- req_valid  in  NUM_CH  request pending per channel
- req_write  in  NUM_CH  1 = write
- req_addr  in  NUM_CH*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_CH*DATA_WIDTH  packed write data
- req_ready  out  NUM_CH  one-hot accept (combinational)
- rsp_valid  out  NUM_CH  one-cycle completion pulse to the owning channel
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_slverr, rsp_timeout  out  1  status, valid with rsp_valid

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Grant points are IDLE, and ACCESS when PREADY=1. At a grant point the arbiter picks the first channel with req_valid set, searching upward from (last_grant+1) mod NUM_CH and wrapping.
- req_ready[g] is high only at a grant point, for the chosen channel g. The request is accepted on the edge where req_valid[g] && req_ready[g]. The requester holds valid and payload until accepted.
- On accept: PADDR, PWRITE and PWDATA are latched from channel g; PSELx = 1<<g; state goes to SETUP; last_grant = g. A read does not change PWDATA.
- SETUP→ACCESS unconditionally; PENABLE=1.
- ACCESS with PREADY=1: rsp_valid[g] pulses. rsp_slverr = PSLVERR. rsp_rdata = PRDATA for a read; for a write it holds its previous value. rsp_timeout = 0. Then:
  - if another request is accepted in the same cycle → SETUP with PENABLE=0;
  - otherwise → IDLE with PSELx=0, PENABLE=0.
- ACCESS with PREADY=0: wait counter increments. When it reaches TIMEOUT_CYCLES (nonzero): rsp_valid[g] pulses with rsp_timeout=1, rsp_slverr=0; PSELx=0, PENABLE=0; state → IDLE. No grant happens that cycle.
- If req_valid drops while not accepted, there is no effect; priority is not consumed.
- Default/illegal state → IDLE with all reset values.

## Timing
- Reset values: state IDLE, PADDR 0, PSELx 0, PENABLE 0, PWRITE 0, PWDATA 0, rsp_* 0, last_grant = NUM_CH-1 (channel 0 has first priority). Wait counter 0.
- Reset is asynchronous. Assertion mid-transfer drops PSEL/PENABLE immediately and produces no rsp_valid.
- Latency: accept edge → SETUP → ACCESS; zero-wait read completes 2 cycles after accept; rsp_valid is registered, 1 cycle after PREADY sample.
- Back-to-back sustained throughput: one transfer per 2 cycles.
- Wait counter clears on every SETUP. A transfer with exactly TIMEOUT_CYCLES-1 wait states completes normally.

## Configuration
- APB4_EN defined:
  - adds PSTRB out DATA_WIDTH/8, PPROT out 3, req_strb in NUM_CH*DATA_WIDTH/8, req_prot in NUM_CH*3;
  - these are latched with the other payload on accept;
  - PSTRB is forced to 0 on reads;
  - reset value 0.
- APB4_EN undefined: these ports are absent; behaviour is APB3 (full-word writes).

## Structure
- Package apb_bridge_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  - the packed response-status struct {slverr, timeout}.
- Sub-module rr_arbiter (parameter N): inputs req[N], advance, last_grant; output one-hot grant. Purely combinational, with the pointer held in the bridge.

## Test plan
- Reset, then ch0 write addr 0x10 data 0xDEADBEEF, PREADY=1 → PSELx=0001 for 2 cycles, PENABLE only in 2nd, rsp_valid=0001, rsp_slverr=0.
- All 4 channels hold reads continuously, PREADY=1 → grant order 0,1,2,3,0; no IDLE between transfers; each rsp_rdata equals the PRDATA driven.
- Ch2 read with PREADY low for 3 cycles, PRDATA=0x1234 → rsp_valid=0100 on the 4th ACCESS cycle, rsp_rdata=0x1234.
- TIMEOUT_CYCLES=16, PREADY held low → abort after 16 ACCESS cycles: rsp_timeout=1, PSELx=0, state IDLE; the next request is then served normally.
- PSLVERR=1 on ch1 write → rsp_slverr=1 with rsp_valid=0010; round-robin pointer advances to ch2.
- PRESETn low during ACCESS → all outputs 0 asynchronously, no rsp_valid; first post-reset grant goes to ch0.
